// File: rtl/bin_window_feeder.sv
// Streams a binarized raster image through KERNEL_DIM-1 line buffers and
// emits every fully populated KERNEL_DIM x KERNEL_DIM window of a frame.
module bin_window_feeder #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int KERNEL_DIM = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             frame_start,
  input  logic                             pixel_valid,
  input  logic                             pixel_in,
  output logic [KERNEL_DIM*KERNEL_DIM-1:0] pixels_out,
  output logic                             window_valid,
  output logic                             busy,
  output logic                             frame_done
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int NB = KERNEL_DIM - 1;
  localparam int WB = KERNEL_DIM * KERNEL_DIM;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          col_q, col_d;
  logic [RW-1:0]          row_q, row_d;
  logic [WB-1:0]          win_q, win_d;
  logic [WB-1:0]          pix_q, pix_d;
  logic [IMG_WIDTH-1:0]   lb_q [NB];
  logic [IMG_WIDTH-1:0]   lb_d [NB];
  logic                   wv_q, wv_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [KERNEL_DIM-1:0]  new_col;

  // Next-state, counter, line-buffer and window computation
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    pix_d   = pix_q;
    lb_d    = lb_q;
    wv_d    = 1'b0;
    done_d  = 1'b0;
    // Row KERNEL_DIM-1 is the live pixel; row j comes from the buffer delayed NB-j rows.
    new_col = '0;
    new_col[KERNEL_DIM-1] = pixel_in;
    for (int j = 0; j < NB; j++) begin
      new_col[j] = lb_q[NB-1-j][IMG_WIDTH-1];
    end

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = RUN;
          col_d   = '0;
          row_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (pixel_valid) begin
          lb_d[0] = {lb_q[0][IMG_WIDTH-2:0], pixel_in};
          for (int b = 1; b < NB; b++) begin
            lb_d[b] = {lb_q[b][IMG_WIDTH-2:0], lb_q[b-1][IMG_WIDTH-1]};
          end
          for (int r = 0; r < KERNEL_DIM; r++) begin
            win_d[r*KERNEL_DIM +: KERNEL_DIM] =
              {new_col[r], win_q[r*KERNEL_DIM+1 +: KERNEL_DIM-1]};
          end
          // Column gating keeps windows from straddling a row wrap.
          wv_d = (row_q >= RW'(NB)) && (col_q >= CW'(NB));
          if (wv_d) begin
            pix_d = win_d;
          end else begin
            pix_d = pix_q;
          end
          if (col_q == CW'(IMG_WIDTH - 1)) begin
            col_d = '0;
            if (row_q == RW'(IMG_HEIGHT - 1)) begin
              row_d   = '0;
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      pix_q   <= '0;
      wv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int b = 0; b < NB; b++) begin
        lb_q[b] <= '0;
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      pix_q   <= pix_d;
      wv_q    <= wv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int b = 0; b < NB; b++) begin
        lb_q[b] <= lb_d[b];
      end
    end
  end

  assign pixels_out   = pix_q;
  assign window_valid = wv_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_bin_window_feeder.sv
// Self-checking bench: directed frame scenarios with random pixels and gaps,
// compared against a window model computed straight from the image array.
module tb_bin_window_feeder;

  localparam int W = 8;
  localparam int H = 8;
  localparam int K = 4;

  logic        clock;
  logic        reset;
  logic        frame_start;
  logic        pixel_valid;
  logic        pixel_in;
  logic [15:0] pixels_out;
  logic        window_valid;
  logic        busy;
  logic        frame_done;

  int          checks = 0;
  int          errors = 0;
  bit          img [H][W];
  logic [15:0] last_win;

  bin_window_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_DIM(K)) dut (
    .clock        (clock),
    .reset        (reset),
    .frame_start  (frame_start),
    .pixel_valid  (pixel_valid),
    .pixel_in     (pixel_in),
    .pixels_out   (pixels_out),
    .window_valid (window_valid),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] exp_win(input int r, input int c);
    logic [15:0] w;
    w = 16'h0000;
    for (int row = 0; row < K; row++)
      for (int col = 0; col < K; col++)
        w[row*K+col] = img[r-K+1+row][c-K+1+col];
    return w;
  endfunction

  // pat: 0 all ones, 1 checkerboard, 2 random; gap: 0 none, 1 alternate, 2 random
  task automatic run_frame(input int pat, input int gap, input bit fs_in_run,
                           input int stop_at, input bit idle_pv);
    int idx, cyc, dut_wins, busy_cyc, r, c;
    bit pv, exp_wv, exp_fd, done;
    for (int rr = 0; rr < H; rr++)
      for (int cc = 0; cc < W; cc++)
        img[rr][cc] = (pat == 0) ? 1'b1 : (pat == 1) ? 1'((rr + cc) % 2)
                                        : 1'($urandom_range(0, 1));
    frame_start = 1'b1;
    pixel_valid = idle_pv;
    pixel_in    = 1'($urandom_range(0, 1));
    step();
    frame_start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("wv_after_start", 32'(window_valid), 32'd0);
    busy_cyc = 1;
    idx = 0; cyc = 0; dut_wins = 0; done = 1'b0;
    while (!done && cyc < 500 && idx < stop_at) begin
      pv = (gap == 0) ? 1'b1 : (gap == 1) ? 1'(cyc % 2) : ($urandom_range(0, 9) < 7);
      r = idx / W;
      c = idx % W;
      pixel_valid = pv;
      pixel_in    = img[r][c];
      frame_start = fs_in_run ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      cyc++;
      exp_wv = pv && r >= K - 1 && c >= K - 1;
      exp_fd = pv && idx == W * H - 1;
      if (pv) idx++;
      if (exp_wv) last_win = exp_win(r, c);
      chk("window_valid", 32'(window_valid), 32'(exp_wv));
      chk("pixels_out", 32'(pixels_out), 32'(last_win));
      chk("frame_done", 32'(frame_done), 32'(exp_fd));
      chk("busy_in_frame", 32'(busy), 32'd1);
      if (window_valid === 1'b1) dut_wins++;
      if (busy === 1'b1) busy_cyc++;
      if (exp_fd) done = 1'b1;
    end
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    if (stop_at >= W * H) begin
      chk("frame_completed", 32'(done), 32'd1);
      chk("window_count", 32'(dut_wins), 32'((W - K + 1) * (H - K + 1)));
      if (gap == 0) chk("busy_cycles", 32'(busy_cyc), 32'(W * H + 1));
      step();
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("wv_after_done", 32'(window_valid), 32'd0);
      chk("fd_after_done", 32'(frame_done), 32'd0);
    end
  endtask

  task automatic idle_cycles(input int n, input bit pv_on);
    for (int i = 0; i < n; i++) begin
      pixel_valid = pv_on ? 1'b1 : 1'($urandom_range(0, 1));
      pixel_in    = 1'($urandom_range(0, 1));
      step();
      chk("idle_wv", 32'(window_valid), 32'd0);
      chk("idle_fd", 32'(frame_done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_pix_hold", 32'(pixels_out), 32'(last_win));
    end
    pixel_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    pixel_in = 1'b0;
    last_win = 16'h0000;
    #1;
    chk("rst_pixels_out", 32'(pixels_out), 32'h0);
    chk("rst_wv", 32'(window_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    step();
    step();
    reset = 1'b0;
    idle_cycles(3, 1'b0);

    run_frame(0, 0, 1'b0, W * H, 1'b0);      // all ones
    run_frame(1, 0, 1'b0, W * H, 1'b0);      // checkerboard
    run_frame(1, 1, 1'b0, W * H, 1'b0);      // checkerboard, alternate gaps
    idle_cycles(10, 1'b1);                   // pixel_valid ignored in IDLE
    run_frame(0, 0, 1'b0, W * H, 1'b1);

    run_frame(2, 2, 1'b0, 30, 1'b0);         // abort after 30 pixels
    reset = 1'b1;
    #1;
    last_win = 16'h0000;
    chk("abort_pixels_out", 32'(pixels_out), 32'h0);
    chk("abort_wv", 32'(window_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_fd", 32'(frame_done), 32'd0);
    step();
    reset = 1'b0;
    idle_cycles(12, 1'b0);
    run_frame(2, 2, 1'b0, W * H, 1'b0);

    run_frame(2, 0, 1'b1, W * H, 1'b0);      // frame_start toggling in RUN
    for (int f = 0; f < 3; f++) begin
      run_frame(2, 2, 1'($urandom_range(0, 1)), W * H, 1'b0);
      idle_cycles(2, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
